// File: rtl/mod_reg16_4to16.sv
// Input-side block buffer: packs four 32-bit writes into a 16-byte block and
// holds it for the cipher datapath until rd_ack consumes it.
module mod_reg16_4to16 #(
  parameter int N     = 16,
  parameter int Nrows = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [8*(N/Nrows)-1:0]   i,
  input  logic                     wr_en,
  input  logic                     rd_ack,
  input  logic                     clr,
  output logic [N-1:0][7:0]        o,
  output logic                     reg_full,
  output logic                     wr_ready,
  output logic                     busy,
  output logic                     ovf
);

  localparam int BPW = N / Nrows;
  localparam int W   = (Nrows > 1) ? $clog2(Nrows) : 1;
  localparam logic [W-1:0] LAST_SLOT = W'(Nrows - 1);

  logic [N-1:0][7:0] o_reg;
  logic [W-1:0]      n_wr_reg;
  logic              reg_full_reg;
  logic              ovf_reg;
  logic              accept;
  logic              consume;

  assign wr_ready = !reg_full_reg | rd_ack;
  assign accept   = wr_en & wr_ready;
  assign consume  = rd_ack & reg_full_reg;

  // Counter, full flag and sticky overflow; a write while full with no ack is dropped.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      n_wr_reg     <= '0;
      reg_full_reg <= 1'b0;
      ovf_reg      <= 1'b0;
    end else if (clr) begin
      n_wr_reg     <= '0;
      reg_full_reg <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      if (accept) begin
        n_wr_reg <= (n_wr_reg == LAST_SLOT) ? '0 : n_wr_reg + 1'b1;
        if (n_wr_reg == LAST_SLOT)
          reg_full_reg <= 1'b1;
        else if (consume)
          reg_full_reg <= 1'b0;
      end else if (consume) begin
        reg_full_reg <= 1'b0;
      end
      if (wr_en && !wr_ready)
        ovf_reg <= 1'b1;
    end
  end

  // One register per block byte; byte gi belongs to word slot gi/BPW.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_byte
      localparam logic [W-1:0] SLOT = W'(gi / BPW);
      localparam int           LANE = gi % BPW;
      always_ff @(posedge clk) begin
        if (!resetn || clr)
          o_reg[gi] <= 8'h00;
        else if (accept && n_wr_reg == SLOT)
          o_reg[gi] <= i[8*LANE +: 8];
      end
    end
  endgenerate

  assign o        = o_reg;
  assign reg_full = reg_full_reg;
  assign ovf      = ovf_reg;
  assign busy     = (n_wr_reg != '0) & !reg_full_reg;

endmodule

// File: tb/tb_mod_reg16_4to16.sv
// Directed bench for mod_reg16_4to16: fill, overflow, ack-with-write, clr and reset cases.
module tb_mod_reg16_4to16;

  logic               clk;
  logic               resetn;
  logic [31:0]        i;
  logic               wr_en;
  logic               rd_ack;
  logic               clr;
  logic [15:0][7:0]   o;
  logic               reg_full;
  logic               wr_ready;
  logic               busy;
  logic               ovf;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] BLK_A  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] BLK_AK = 128'h0F0E0D0C_0B0A0908_07060504_AABBCCDD;
  localparam logic [127:0] BLK_B  = 128'h00FFEEDD_CCBBAA99_88776655_44332211;
  localparam logic [127:0] BLK_C  = 128'hAFAEADAC_ABAAA9A8_A7A6A5A4_A3A2A1A0;

  mod_reg16_4to16 dut (
    .clk      (clk),
    .resetn   (resetn),
    .i        (i),
    .wr_en    (wr_en),
    .rd_ack   (rd_ack),
    .clr      (clr),
    .o        (o),
    .reg_full (reg_full),
    .wr_ready (wr_ready),
    .busy     (busy),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {reg_full, busy, ovf, wr_ready}
  function automatic logic [127:0] flags();
    return {124'd0, reg_full, busy, ovf, wr_ready};
  endfunction

  task automatic wr_word(input logic [31:0] w);
    wr_en = 1'b1;
    i     = w;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    logic [31:0] wa [4];
    logic [31:0] wb [4];
    logic [31:0] wc [4];
    wa = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    wb = '{32'h44332211, 32'h88776655, 32'hCCBBAA99, 32'h00FFEEDD};
    wc = '{32'hA3A2A1A0, 32'hA7A6A5A4, 32'hABAAA9A8, 32'hAFAEADAC};

    resetn = 1'b0; i = '0; wr_en = 1'b0; rd_ack = 1'b0; clr = 1'b0;
    tick();
    resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("idle_o", o, 128'd0);
      chk("idle_flags", flags(), 128'b0001);
    end

    // Fill with bytes 0..15
    for (int k = 0; k < 4; k++) begin
      wr_word(wa[k]);
      if (k < 3) chk("fill_busy_flags", flags(), 128'b0101);
    end
    chk("fill_o", o, BLK_A);
    chk("fill_full_flags", flags(), 128'b1000);

    // Overflow while full
    wr_word(32'hDEADBEEF);
    chk("ovf_o", o, BLK_A);
    chk("ovf_flags", flags(), 128'b1010);
    rd_ack = 1'b1;
    #1;
    chk("ack_ready_comb", {127'd0, wr_ready}, 128'd1);
    tick();
    rd_ack = 1'b0;
    chk("ack_flags", flags(), 128'b0011);
    chk("ack_o_stale", o, BLK_A);

    // Refill, then ack and write in the same cycle
    for (int k = 0; k < 4; k++) wr_word(wa[k]);
    chk("refill_o", o, BLK_A);
    rd_ack = 1'b1;
    wr_word(32'hAABBCCDD);
    rd_ack = 1'b0;
    chk("ackwr_flags", flags(), 128'b0111);
    chk("ackwr_o", o, BLK_AK);

    // Second word, then clr with a concurrent write
    wr_word(32'h11111111);
    chk("pre_clr_o", o, 128'h0F0E0D0C_0B0A0908_11111111_AABBCCDD);
    clr = 1'b1;
    wr_word(32'h22222222);
    clr = 1'b0;
    chk("clr_o", o, 128'd0);
    chk("clr_flags", flags(), 128'b0001);
    for (int k = 0; k < 4; k++) begin
      wr_word(wb[k]);
      if (k == 0) chk("post_clr_slot0", o, 128'h44332211);
    end
    chk("post_clr_o", o, BLK_B);
    chk("post_clr_flags", flags(), 128'b1000);

    // Consume, 3 words, then reset mid-fill
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    wr_word(32'h01010101);
    wr_word(32'h02020202);
    wr_word(32'h03030303);
    chk("pre_rst_flags", flags(), 128'b0101);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("rst_o", o, 128'd0);
    chk("rst_flags", flags(), 128'b0001);
    for (int k = 0; k < 4; k++) begin
      wr_word(wc[k]);
      if (k == 0) chk("post_rst_slot0", o, 128'hA3A2A1A0);
    end
    chk("post_rst_o", o, BLK_C);
    chk("post_rst_flags", flags(), 128'b1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_reg16_4to16.md
# mod_reg16_4to16

Input-side block buffer for the AES256 core and the write-direction counterpart of the 16-to-4 output register. It accepts four 32-bit words from the AXI slave side, one per accepted write, and packs them into a 16-byte block (state or key half). When all four words have arrived it presents the block in parallel to the cipher datapath. It holds the block until the datapath acknowledges consumption.

## Interface
- N, 16, number of bytes per block
- Nrows, 4, number of 32-bit words per block (N/Nrows = 4 bytes per word)
- clk  input  1  clock; all state updates on rising edge
- resetn  input  1  reset, synchronous, active-low
- i  input  32  incoming word; byte j is i[8j+7:8j]
- wr_en  input  1  word valid from AXI side; one word per cycle when high
- rd_ack  input  1  datapath has consumed the block
- clr  input  1  synchronous abort; discards any partial or full block
- o  output  [N-1:0][7:0]  assembled block, registered
- reg_full  output  1  block complete and valid on o
- wr_ready  output  1  combinational, equal to !reg_full | rd_ack
- busy  output  1  partial block held (1 to 3 words written, not full)
- ovf  output  1  sticky overflow flag

## Operation
- Internal 2-bit word counter n_wr gives the next word slot.
- State is derived from the counter:
  - EMPTY: n_wr=0 and reg_full=0
  - FILL: n_wr in 1..3
  - FULL: reg_full=1, n_wr=0
- Accept condition: wr_en & wr_ready. On accept, for j=0..3: o[4*n_wr+j] <= i[8j+:8].
- Resulting byte order: word 0 fills bytes 0..3, word 3 fills bytes 12..15, so o[0] = i[7:0] of the first word.
- On accept, n_wr <= n_wr+1 with wrap to 0. When n_wr==3, reg_full <= 1.
- Consumption: rd_ack while reg_full sets reg_full <= 0. o keeps its stale value until overwritten.
- rd_ack while not full is ignored.
- Simultaneous rd_ack and wr_en while FULL:
  - the block is consumed
  - the word is written into slot 0
  - n_wr becomes 1 and reg_full becomes 0
  - the datapath samples the old o before the edge, so no data is lost
- Overflow: wr_en while reg_full and no rd_ack. The word is dropped, nothing else changes, and ovf <= 1.
- ovf stays high until clr or reset.
- busy = (n_wr != 0) & !reg_full.
- Priority, highest first: reset, clr, accept/consume logic.
- clr sets n_wr <= 0, reg_full <= 0, ovf <= 0 and o <= 0. It ignores wr_en and rd_ack in the same cycle.

## Timing
- Reset values, applied on the rising edge with resetn=0: o=0, reg_full=0, busy=0, ovf=0, n_wr=0. wr_ready is therefore 1.
- Write latency: a word accepted at edge k is visible on o after edge k.
- Fill latency: reg_full rises after the edge that accepts the 4th word. The minimum is 4 cycles from the first word when wr_en is held high.
- Sustained throughput: one block every 4 cycles, provided rd_ack is asserted in the cycle reg_full is high and a new word is presented in that same cycle.
- reg_full and busy are registered. wr_ready is the only combinational output.
- Reset or clr mid-fill discards the partial block completely. The next accepted word goes to slot 0.

## Test plan
- Reset, then idle: all outputs at their reset values for 3 cycles; wr_ready=1.
- Write 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C on consecutive cycles:
  - o[k] = k for k = 0..15
  - busy=1 after words 1 to 3
  - reg_full=1 after word 4, busy=0
- With the buffer full, write 0xDEADBEEF with rd_ack=0:
  - o unchanged, ovf=1
  - then rd_ack=1 gives reg_full=0, and ovf stays 1
- With the buffer full, assert rd_ack and write 0xAABBCCDD in the same cycle:
  - reg_full=0, busy=1
  - o[0..3] = DD, CC, BB, AA; o[4..15] keep their old values
- After 2 words, pulse clr together with wr_en:
  - o=0, busy=0, ovf=0, and the word is dropped
  - then 4 new words form a complete block starting at o[0]
- After 3 words, drive resetn=0 for one cycle: reset values return, and the next 4 words fill the block from slot 0.
